ahb_sram_slave: RTL
===================

Name: ahb_sram_slave

Overview:
- AHB-Lite responder (slave) that serves word, halfword and byte transfers from an internal register-array SRAM.
- It sits on the bus driven by the RV-core AHB initiator, as the data-RAM target.
- Supports a parameterised number of wait states and an optional two-cycle ERROR response.
- Single clock domain, one outstanding transfer, standard pipelined AHB-Lite address/data phases.

Parameters:
- ADDR_W, 10, word-index bits; depth = 2**ADDR_W 32-bit words (4 KiB default).
- BASE_ADDR, 32'h0000_0000, byte base address of the window; must be aligned to 4*2**ADDR_W.
- WAIT_STATES, 0, data-phase cycles with HREADYOUT=0 before completion (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from address decoder.
- HADDR  in  32  byte address, address phase.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  000 byte, 001 half, 010 word; others are illegal.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus-level ready; qualifies the address phase.
- HRDATA  out  32  read data, data phase.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0, no pending write. Memory contents are not reset.
- Address-phase accept: HSEL & HREADY & HTRANS[1] on a rising edge. On accept, register:
  - word index HADDR[ADDR_W+1:2];
  - byte enables, from HSIZE and HADDR[1:0];
  - HWRITE;
  - error flag.
- IDLE/BUSY transfers, or HSEL=0: no access; the next cycle is a zero-wait OKAY (HREADYOUT=1, HRESP=0).
- Byte-enable lanes:
  - byte: lane HADDR[1:0];
  - half: lanes {1,0} if HADDR[1]=0, else lanes {3,2};
  - word: all four lanes.
- Error condition, any of:
  - HSIZE>2;
  - half with HADDR[0]=1;
  - word with HADDR[1:0]!=0;
  - HADDR outside [BASE_ADDR, BASE_ADDR+4*2**ADDR_W).
- States: IDLE, WAIT, ERR1, ERR2.
- IDLE:
  - Accept with error → ERR1.
  - Accept with WAIT_STATES>0 → WAIT, counter loaded to WAIT_STATES.
  - Otherwise remain IDLE; the data phase completes next cycle with HREADYOUT=1.
- WAIT: HREADYOUT=0 and the counter decrements each cycle. When the counter reaches 0, HREADYOUT=1 (completion cycle), then return to IDLE, or accept a new address phase in that same cycle.
- ERR1: HREADYOUT=0, HRESP=1 → ERR2.
- ERR2: HREADYOUT=1, HRESP=1; a new address phase may be accepted in this cycle. Errored transfers never write memory.
- Read: in the completion cycle, HRDATA = mem[index_q], full word on all lanes regardless of size. In all other cycles HRDATA=0.
- Write: on the completion-cycle edge, HWDATA is written to mem[index_q] for the enabled lanes only.
- Back-to-back write then read of the same address: the read sees the new data. Reads are combinational from the array at index_q, and the write commits on the edge before the read's data phase.
- While HREADYOUT=0, new address phases are not accepted, because the bus HREADY is low.
- Reset asserted mid-transfer: the transfer is aborted, the pending write is dropped, and all outputs return to their reset values.

Optional Feature:
- Macro: AHB_SRAM_ERR_EN.
- Defined: error detection and the two-cycle ERR1/ERR2 response as above.
- Undefined:
  - HRESP is tied to 0 and states ERR1/ERR2 are removed;
  - out-of-range addresses alias (upper bits ignored);
  - misaligned halfword/word accesses use HADDR[1:0] forced to the aligned lane set;
  - HSIZE>2 is treated as word.

Decomposition:
- Package ahb_pkg:
  - HTRANS encodings (HTRANS_IDLE/BUSY/NONSEQ/SEQ);
  - HSIZE encodings;
  - HRESP_OKAY/HRESP_ERROR;
  - typedef enum slave_state_t {IDLE, WAIT, ERR1, ERR2}.
- Sub-module ahb_be_decode: combinational HSIZE/HADDR[1:0] → 4-bit byte enable plus misalign flag.

Test Plan:
- Reset: hold reset=0 for 3 cycles → HREADYOUT=1, HRESP=0, HRDATA=0; release, then IDLE transfers → OKAY, zero wait.
- Word write then read, WAIT_STATES=0: write 0xDEADBEEF @0x10; read @0x10 back-to-back → HRDATA=0xDEADBEEF in the read data phase, no wait cycles.
- Byte/half lanes: word 0x11223344 @0x20; byte write 0xAA to 0x23; half write 0x5566 to 0x20 → read 0xAA225566.
- Wait states, WAIT_STATES=3: read @0x10 → HREADYOUT low for exactly 3 cycles, then high with data; next NONSEQ accepted on the completion cycle.
- Error, AHB_SRAM_ERR_EN defined: word write @0x02 (misaligned) and read @BASE+0x1000 (out of range) → each gives HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; memory @0x00 unchanged.
- Reset mid-WAIT: assert reset during wait cycle 2 of a write of 0x12345678 @0x30 → outputs return to reset values and a later read @0x30 shows the old contents.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM responder's FSM state type.
// States ERR1/ERR2 exist only when AHB_SRAM_ERR_EN is defined.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

`ifdef AHB_SRAM_ERR_EN
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR1 = 2'b10,
    ERR2 = 2'b11
  } slave_state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01
  } slave_state_t;
`endif

endpackage

// File: rtl/ahb_be_decode.sv
// Byte-lane decoder: HSIZE and the low address bits to a 4-bit lane mask,
// plus a flag for misaligned or illegal-size transfers.
module ahb_be_decode
  import ahb_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] be_o,
  output logic       misalign_o
);

  // Lane mask always falls on the naturally aligned lane set for the size.
  always_comb begin
    be_o       = 4'b1111;
    misalign_o = 1'b0;
    case (size_i)
      HSIZE_BYTE: be_o = 4'b0001 << addr_lo_i;
      HSIZE_HALF: begin
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_lo_i[0];
      end
      HSIZE_WORD: misalign_o = (addr_lo_i != 2'b00);
      default:    misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder with configurable wait states.
// Define AHB_SRAM_ERR_EN for misalign/range checking and the two-cycle ERROR response.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [31:0]       mem_q [DEPTH];
  slave_state_t      state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [3:0]        be_q, be_d;
  logic              write_q, write_d;
  logic              act_q, act_d;

  logic              accept_s;
  logic              ready_s;
  logic              done_s;
  logic [3:0]        be_s;
  logic              misalign_s;
  logic              unused_s;

  ahb_be_decode u_be_decode (
    .size_i     (HSIZE),
    .addr_lo_i  (HADDR[1:0]),
    .be_o       (be_s),
    .misalign_o (misalign_s)
  );

  assign accept_s = HSEL & HREADY & HTRANS[1];

`ifdef AHB_SRAM_ERR_EN
  logic err_s;
  assign err_s    = misalign_s | (HADDR[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);
  assign unused_s = HTRANS[0];
`else
  assign unused_s = ^{HTRANS[0], HADDR[31:ADDR_W+2], BASE_ADDR, misalign_s};
`endif

  // Ready/response decode from the current state.
  always_comb begin
    ready_s = 1'b1;
    HRESP   = HRESP_OKAY;
    case (state_q)
      WAIT: ready_s = (cnt_q == 4'd0);
`ifdef AHB_SRAM_ERR_EN
      ERR1: begin
        ready_s = 1'b0;
        HRESP   = HRESP_ERROR;
      end
      ERR2: HRESP = HRESP_ERROR;
`endif
      default: ready_s = 1'b1;
    endcase
  end

  assign HREADYOUT = ready_s;
  // A data phase completes on the first ready cycle after a good accept.
  assign done_s    = act_q & ready_s;
  assign HRDATA    = (done_s && !write_q) ? mem_q[index_q] : 32'h0000_0000;

  // Next-state: count down waits, walk the error pair, or take a new address phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    be_d    = be_q;
    write_d = write_q;
    act_d   = act_q;
    if (!ready_s) begin
      case (state_q)
        WAIT:    cnt_d   = cnt_q - 4'd1;
`ifdef AHB_SRAM_ERR_EN
        ERR1:    state_d = ERR2;
`endif
        default: state_d = IDLE;
      endcase
    end else if (accept_s) begin
      index_d = HADDR[ADDR_W+1:2];
      be_d    = be_s;
      write_d = HWRITE;
`ifdef AHB_SRAM_ERR_EN
      if (err_s) begin
        state_d = ERR1;
        act_d   = 1'b0;
      end else
`endif
      if (WAIT_STATES != 0) begin
        state_d = WAIT;
        cnt_d   = 4'(WAIT_STATES);
        act_d   = 1'b1;
      end else begin
        state_d = IDLE;
        act_d   = 1'b1;
      end
    end else begin
      state_d = IDLE;
      act_d   = 1'b0;
    end
  end

  // Control registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      index_q <= {ADDR_W{1'b0}};
      be_q    <= 4'b0000;
      write_q <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      index_q <= index_d;
      be_q    <= be_d;
      write_q <= write_d;
      act_q   <= act_d;
    end
  end

  // Storage array, not reset; write commits on the completion edge.
  always_ff @(posedge clk) begin
    if (done_s && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[index_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule
